hack_cpu_mc: RTL and testbench



---
 rtl/hack_cpu_mc_pkg.sv | 30 +++
 rtl/hack_cpu_mc_if.sv | 26 ++
 rtl/hack_cpu_mc_alu.sv | 29 ++
 rtl/hack_cpu_mc.sv | 169 ++++++++++++++++
 tb/tb_hack_cpu_mc.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_cpu_mc_pkg.sv
// Shared types and instruction-field positions for the multicycle Hack CPU.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MREAD,
    EXEC,
    MWRITE,
    HALT
  } state_e;

  localparam int I_BIT = 15;
  localparam int A_BIT = 12;
  localparam int C_ZX  = 11;
  localparam int C_NX  = 10;
  localparam int C_ZY  = 9;
  localparam int C_NY  = 8;
  localparam int C_F   = 7;
  localparam int C_NO  = 6;
  localparam int D_A   = 5;
  localparam int D_D   = 4;
  localparam int D_M   = 3;
  localparam int J_LO  = 0;

  function automatic logic jump_taken(input logic [2:0] jbits, input logic zr, input logic ng);
    return (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory req/ack bus between the CPU (master) and memories (slave).
interface hack_cpu_mc_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WIDTH-1:0]  dmem_wdata;
  logic [WIDTH-1:0]  dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU generalised to WIDTH bits.
module hack_alu_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x1, x2, y1, y2, o1;

  always_comb begin
    x1  = zx ? '0 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? '0 : y;
    y2  = ny ? ~y1 : y1;
    o1  = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~o1 : o1;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end
endmodule

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU with req/ack instruction and data ports, retire counter
// and optional halt on the end-of-program self-loop.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int ADDR_W           = 15,
  parameter int CNT_W            = 32,
  parameter bit HALT_ON_SELFLOOP = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  hack_cpu_mc_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic [WIDTH-1:0]  a_reg,
  output logic [WIDTH-1:0]  d_reg,
  output logic              retire,
  output logic              halted,
  output logic [CNT_W-1:0]  instret
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  areg_q, areg_d, dreg_q, dreg_d;
  logic [WIDTH-1:0]  m_q, m_d, res_q, res_d;
  logic [15:0]       ir_q, ir_d;
  logic              jmp_q, jmp_d, retire_q, retire_d, halted_q, halted_d;
  logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [WIDTH-1:0]  alu_y, alu_out, c_res;
  logic              alu_zr, alu_ng, commit, c_jmp;
  logic [ADDR_W-1:0] old_a, pc_inc;

  assign alu_y  = ir_q[A_BIT] ? m_q : areg_q;
  assign old_a  = areg_q[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  hack_alu_w #(.WIDTH(WIDTH)) u_alu (
    .x(dreg_q), .y(alu_y),
    .zx(ir_q[C_ZX]), .nx(ir_q[C_NX]), .zy(ir_q[C_ZY]),
    .ny(ir_q[C_NY]), .f(ir_q[C_F]), .no(ir_q[C_NO]),
    .out(alu_out), .zr(alu_zr), .ng(alu_ng)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    areg_d   = areg_q;
    dreg_d   = dreg_q;
    m_d      = m_q;
    res_d    = res_q;
    ir_d     = ir_q;
    jmp_d    = jmp_q;
    halted_d = halted_q;
    retire_d = 1'b0;
    commit   = 1'b0;
    c_res    = res_q;
    c_jmp    = jmp_q;

    case (state_q)
      FETCH: begin
        if (imem_req_q && bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[I_BIT]) begin
          areg_d   = WIDTH'(ir_q[14:0]);
          pc_d     = pc_inc;
          retire_d = 1'b1;
          state_d  = FETCH;
        end else if (ir_q[A_BIT]) begin
          state_d = MREAD;
        end else begin
          state_d = EXEC;
        end
      end
      MREAD: begin
        if (dmem_req_q && bus.dmem_ack) begin
          m_d     = bus.dmem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = alu_out;
        jmp_d = jump_taken(ir_q[J_LO +: 3], alu_zr, alu_ng);
        if (ir_q[D_M]) begin
          state_d = MWRITE;
        end else begin
          commit = 1'b1;
          c_res  = alu_out;
          c_jmp  = jmp_d;
        end
      end
      MWRITE: begin
        if (dmem_req_q && bus.dmem_ack) commit = 1'b1;
      end
      default: state_d = HALT;
    endcase

    // All commit effects use the A value from before this instruction's writeback.
    if (commit) begin
      if (ir_q[D_D]) dreg_d = c_res;
      if (ir_q[D_A]) areg_d = c_res;
      pc_d     = c_jmp ? old_a : pc_inc;
      retire_d = 1'b1;
      if (HALT_ON_SELFLOOP && c_jmp && (old_a == pc_q)) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else begin
        state_d = FETCH;
      end
    end

    instret_d  = retire_d ? instret_q + CNT_W'(1) : instret_q;
    imem_req_d = (state_d == FETCH);
    dmem_req_d = (state_d == MREAD) || (state_d == MWRITE);
    dmem_we_d  = (state_d == MWRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      areg_q     <= '0;
      dreg_q     <= '0;
      ir_q       <= '0;
      jmp_q      <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      areg_q     <= areg_d;
      dreg_q     <= dreg_d;
      ir_q       <= ir_d;
      jmp_q      <= jmp_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      instret_q  <= instret_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  always_ff @(posedge clk) begin
    m_q   <= m_d;
    res_q <= res_d;
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = old_a;
  assign bus.dmem_wdata = res_q;
  assign pc      = pc_q;
  assign a_reg   = areg_q;
  assign d_reg   = dreg_q;
  assign retire  = retire_q;
  assign halted  = halted_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: directed programs, wait-stated memory models,
// retire and data-access monitors comparing against hand-computed expectations.
module tb_hack_cpu_mc;
  typedef struct {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    logic [31:0] n;
  } ret_t;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] pc;
  logic [15:0] a_reg, d_reg;
  logic        retire, halted;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  int iwait = 0;
  int dwait = 0;
  int icnt  = 0;
  int dcnt  = 0;
  logic [63:0] dlatch;

  logic [15:0] imem [0:63];
  logic [15:0] dmem [0:127];
  ret_t rq[$];
  mem_t mq[$];

  hack_cpu_mc_if #(.WIDTH(16), .ADDR_W(15)) bus ();

  hack_cpu_mc #(.WIDTH(16), .ADDR_W(15), .CNT_W(32), .HALT_ON_SELFLOOP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg),
    .retire(retire), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_ret(input logic [14:0] p, input logic [15:0] a, input logic [15:0] d, input logic [31:0] n);
    ret_t r;
    r.pc = p; r.a = a; r.d = d; r.n = n;
    rq.push_back(r);
  endtask

  task automatic exp_mem(input logic we, input logic [14:0] addr, input logic [15:0] wdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    mq.push_back(m);
  endtask

  // Instruction memory responder with iwait wait cycles per fetch.
  always @(negedge clk) begin
    if (!reset_n || !bus.imem_req) begin
      bus.imem_ack = 1'b0;
      icnt = 0;
    end else if (icnt >= iwait) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = imem[bus.imem_addr[5:0]];
      icnt = 0;
    end else begin
      bus.imem_ack = 1'b0;
      icnt++;
    end
  end

  // Data memory responder: checks the request stays stable while stalled, and
  // compares each completed access against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n || !bus.dmem_req) begin
      bus.dmem_ack = 1'b0;
      dcnt = 0;
    end else begin
      if (dcnt == 0)
        dlatch = {17'd0, pc, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
      else
        chk("dmem_hold", {17'd0, pc, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, dlatch);
      if (dcnt >= dwait) begin
        bus.dmem_ack = 1'b1;
        dcnt = 0;
        if (mq.size() == 0) begin
          chk("dmem_unexpected", {bus.dmem_we, bus.dmem_addr}, 64'hFFFF_FFFF);
        end else begin
          mem_t m;
          m = mq.pop_front();
          chk("dmem_we", bus.dmem_we, m.we);
          chk("dmem_addr", bus.dmem_addr, m.addr);
          if (m.we) chk("dmem_wdata", bus.dmem_wdata, m.wdata);
        end
        if (bus.dmem_we) dmem[bus.dmem_addr[6:0]] = bus.dmem_wdata;
        else bus.dmem_rdata = dmem[bus.dmem_addr[6:0]];
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt++;
      end
    end
  end

  // Retire monitor.
  always @(negedge clk) begin
    if (reset_n && retire) begin
      if (rq.size() == 0) begin
        chk("retire_unexpected", {pc, instret}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        ret_t r;
        r = rq.pop_front();
        chk("ret_pc", pc, r.pc);
        chk("ret_a", a_reg, r.a);
        chk("ret_d", d_reg, r.d);
        chk("ret_instret", instret, r.n);
      end
    end
  end

  task automatic start(input int iw, input int dw);
    @(posedge clk);
    #1 reset_n = 1'b0;
    iwait = iw;
    dwait = dw;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 128; i++) dmem[i] = 16'h0000;
  endtask

  task automatic go();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_imem_req", bus.imem_req, 1'b1);
    chk("rel_imem_addr", bus.imem_addr, 15'd0);
  endtask

  task automatic wait_halt(input logic [14:0] exp_pc);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    chk("halt_reached", halted, 1'b1);
    chk("halt_pc", pc, exp_pc);
    repeat (4) @(posedge clk);
    #1;
    chk("halt_no_req", {bus.imem_req, bus.dmem_req}, 2'b00);
    chk("ret_queue_empty", rq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);
  endtask

  task automatic load_jlt();
    imem[0] = 16'hEE90; imem[1] = 16'h0014; imem[2] = 16'hE304;
    imem[20] = 16'h0015; imem[21] = 16'hEA87;
    exp_ret(15'd1, 16'd0, 16'hFFFF, 1);
    exp_ret(15'd2, 16'd20, 16'hFFFF, 2);
    exp_ret(15'd20, 16'd20, 16'hFFFF, 3);
    exp_ret(15'd21, 16'd21, 16'hFFFF, 4);
    exp_ret(15'd21, 16'd21, 16'hFFFF, 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // @5 ; D=A ; @3 ; 0;JMP with zero-wait memories and cycle-exact checks
    start(0, 0);
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hEA87;
    exp_ret(15'd1, 16'd5, 16'd0, 1);
    exp_ret(15'd2, 16'd5, 16'd5, 2);
    exp_ret(15'd3, 16'd3, 16'd5, 3);
    exp_ret(15'd3, 16'd3, 16'd5, 4);
    go();
    repeat (2) @(posedge clk);
    #1 chk("t2_a_after_2", a_reg, 16'd5);
    repeat (2) @(posedge clk);
    #1 chk("t2_d_before_5", d_reg, 16'd0);
    @(posedge clk);
    #1 chk("t2_d_after_5", d_reg, 16'd5);
    wait_halt(15'd3);

    // @7 ; D=A ; @100 ; M=D+1 with a 3-cycle data write stall
    start(0, 3);
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE7C8;
    imem[4] = 16'h0005; imem[5] = 16'hEA87;
    exp_ret(15'd1, 16'd7, 16'd0, 1);
    exp_ret(15'd2, 16'd7, 16'd7, 2);
    exp_ret(15'd3, 16'd100, 16'd7, 3);
    exp_ret(15'd4, 16'd100, 16'd7, 4);
    exp_ret(15'd5, 16'd5, 16'd7, 5);
    exp_ret(15'd5, 16'd5, 16'd7, 6);
    exp_mem(1'b1, 15'd100, 16'd8);
    go();
    wait_halt(15'd5);
    chk("t3_dmem100", dmem[100], 16'd8);

    // @3 ; D=M ; M=M+1 with instruction and data wait states
    start(2, 1);
    dmem[3] = 16'h1234;
    imem[0] = 16'h0003; imem[1] = 16'hFC10; imem[2] = 16'hFDC8;
    imem[3] = 16'h0004; imem[4] = 16'hEA87;
    exp_ret(15'd1, 16'd3, 16'h0000, 1);
    exp_ret(15'd2, 16'd3, 16'h1234, 2);
    exp_ret(15'd3, 16'd3, 16'h1234, 3);
    exp_ret(15'd4, 16'd4, 16'h1234, 4);
    exp_ret(15'd4, 16'd4, 16'h1234, 5);
    exp_mem(1'b0, 15'd3, 16'h0000);
    exp_mem(1'b0, 15'd3, 16'h0000);
    exp_mem(1'b1, 15'd3, 16'h1235);
    go();
    wait_halt(15'd4);
    chk("t4_dmem3", dmem[3], 16'h1235);

    // D=-1 ; @20 ; D;JLT taken
    start(0, 0);
    load_jlt();
    go();
    wait_halt(15'd21);

    // D=0 ; @20 ; D;JGT not taken
    start(0, 0);
    imem[0] = 16'hEA90; imem[1] = 16'h0014; imem[2] = 16'hE301;
    imem[3] = 16'h0004; imem[4] = 16'hEA87;
    exp_ret(15'd1, 16'd0, 16'd0, 1);
    exp_ret(15'd2, 16'd20, 16'd0, 2);
    exp_ret(15'd3, 16'd20, 16'd0, 3);
    exp_ret(15'd4, 16'd4, 16'd0, 4);
    exp_ret(15'd4, 16'd4, 16'd0, 5);
    go();
    wait_halt(15'd4);

    // Jump to 10, then @11 ; 0;JMP self-loop halts; reset clears halt
    start(0, 0);
    imem[0] = 16'h000A; imem[1] = 16'hEA87; imem[10] = 16'h000B; imem[11] = 16'hEA87;
    exp_ret(15'd1, 16'd10, 16'd0, 1);
    exp_ret(15'd10, 16'd10, 16'd0, 2);
    exp_ret(15'd11, 16'd11, 16'd0, 3);
    exp_ret(15'd11, 16'd11, 16'd0, 4);
    go();
    wait_halt(15'd11);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_halted", halted, 1'b0);
    chk("t6_rst_pc", pc, 15'd0);
    chk("t6_rst_a", a_reg, 16'd0);
    chk("t6_rst_imem_req", bus.imem_req, 1'b0);
    go();

    // Asynchronous reset in the middle of a running program
    start(0, 0);
    load_jlt();
    go();
    begin
      int n;
      n = 0;
      while (rq.size() > 3 && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      chk("mid_progress", rq.size() <= 3, 1'b1);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 15'd0);
    chk("mid_rst_a", a_reg, 16'd0);
    chk("mid_rst_d", d_reg, 16'd0);
    chk("mid_rst_instret", instret, 32'd0);
    chk("mid_rst_reqs", {bus.imem_req, bus.dmem_req, bus.dmem_we, retire, halted}, 5'd0);
    rq.delete();
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_held_req", bus.imem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
